// File: rtl/tournament_bpu.sv
// Tournament branch predictor: per-PC local history + gshare, picked by a 2-bit chooser.
// Predicts B-type branches combinationally; resolved outcomes update through a 2-stage RMW pipe.
module tournament_bpu #(
    parameter int unsigned LHT_BITS   = 10,
    parameter int unsigned LHIST_BITS = 10,
    parameter int unsigned GHIST_BITS = 12,
    parameter int unsigned CHO_BITS   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           inst_i,
    output logic                  pre_branch_flag_o,
    output logic [31:0]           pre_branch_target_address_o,
    output logic                  pre_take_or_not,
    output logic                  pre_sel,
    output logic                  pre_lpred,
    output logic                  pre_gpred,
    output logic [GHIST_BITS-1:0] pre_gidx,
    input  logic                  id_is_branch,
    input  logic [31:0]           id_pc,
    input  logic                  id_take_or_not,
    input  logic                  id_lpred,
    input  logic                  id_gpred,
    input  logic [GHIST_BITS-1:0] id_gidx,
    output logic                  bpu_ready_o
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int unsigned MAX_L = (LHT_BITS > LHIST_BITS) ? LHT_BITS : LHIST_BITS;
    localparam int unsigned MAX_G = (GHIST_BITS > CHO_BITS) ? GHIST_BITS : CHO_BITS;
    localparam int unsigned SWEEP_BITS = (MAX_L > MAX_G) ? MAX_L : MAX_G;

    typedef enum logic {StInit, StRun} state_e;

    state_e                  state_q;
    logic [SWEEP_BITS-1:0]   cnt_q;
    logic [GHIST_BITS-1:0]   ghist_q;

    logic [LHIST_BITS-1:0] lht  [0:(1<<LHT_BITS)-1];
    logic [1:0]            lpht [0:(1<<LHIST_BITS)-1];
    logic [1:0]            gpht [0:(1<<GHIST_BITS)-1];
    logic [1:0]            cho  [0:(1<<CHO_BITS)-1];

    // U1 -> U2 pipeline registers
    logic                  u_valid_q;
    logic                  u_taken_q;
    logic                  u_lpred_q;
    logic                  u_gpred_q;
    logic [LHT_BITS-1:0]   u_lht_idx_q;
    logic [CHO_BITS-1:0]   u_cho_idx_q;
    logic [GHIST_BITS-1:0] u_gidx_q;
    logic [LHIST_BITS-1:0] u_lh_q;
    logic [1:0]            u_lcnt_q;
    logic [1:0]            u_gcnt_q;
    logic [1:0]            u_ccnt_q;

    function automatic logic [1:0] ctr_step(logic [1:0] c, logic up);
        if (up) return (c == 2'd3) ? c : c + 2'd1;
        else    return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    // Prediction path
    logic                  p_is_br;
    logic [LHIST_BITS-1:0] p_lh;
    logic [GHIST_BITS-1:0] p_gidx;
    logic                  p_lpred, p_gpred, p_sel, p_take;
    logic [31:0]           p_bimm;

    assign p_is_br = (state_q == StRun) && (inst_i[6:0] == OP_BRANCH);
    assign p_lh    = lht[pc_i[LHT_BITS+1:2]];
    assign p_gidx  = ghist_q ^ pc_i[GHIST_BITS+1:2];
    assign p_lpred = lpht[p_lh][1];
    assign p_gpred = gpht[p_gidx][1];
    assign p_sel   = cho[pc_i[CHO_BITS+1:2]][1];
    assign p_take  = p_sel ? p_gpred : p_lpred;
    assign p_bimm  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

    always_comb begin
        pre_branch_flag_o           = 1'b0;
        pre_branch_target_address_o = 32'h0;
        pre_take_or_not             = 1'b0;
        pre_sel                     = 1'b0;
        pre_lpred                   = 1'b0;
        pre_gpred                   = 1'b0;
        pre_gidx                    = '0;
        if (p_is_br) begin
            pre_branch_flag_o           = 1'b1;
            pre_branch_target_address_o = pc_i + (p_take ? p_bimm : 32'd4);
            pre_take_or_not             = p_take;
            pre_sel                     = p_sel;
            pre_lpred                   = p_lpred;
            pre_gpred                   = p_gpred;
            pre_gidx                    = p_gidx;
        end
    end

    assign bpu_ready_o = (state_q == StRun);

    // U2 write values
    logic [LHIST_BITS-1:0] lht_wr;
    logic [1:0]            lcnt_wr, gcnt_wr, ccnt_wr;

    assign lht_wr  = {u_lh_q[LHIST_BITS-2:0], u_taken_q};
    assign lcnt_wr = ctr_step(u_lcnt_q, u_taken_q);
    assign gcnt_wr = ctr_step(u_gcnt_q, u_taken_q);
    // When the components disagree exactly one was right; move toward it.
    assign ccnt_wr = (u_lpred_q != u_gpred_q) ? ctr_step(u_ccnt_q, u_gpred_q == u_taken_q)
                                              : u_ccnt_q;

    // U1 reads, forwarded from an in-flight U2 write to the same entry
    logic [LHT_BITS-1:0]   id_lht_idx;
    logic [CHO_BITS-1:0]   id_cho_idx;
    logic [LHIST_BITS-1:0] f_lh;
    logic [1:0]            f_lcnt, f_gcnt, f_ccnt;

    assign id_lht_idx = id_pc[LHT_BITS+1:2];
    assign id_cho_idx = id_pc[CHO_BITS+1:2];
    assign f_lh   = (u_valid_q && u_lht_idx_q == id_lht_idx) ? lht_wr : lht[id_lht_idx];
    assign f_lcnt = (u_valid_q && u_lh_q == f_lh) ? lcnt_wr : lpht[f_lh];
    assign f_gcnt = (u_valid_q && u_gidx_q == id_gidx) ? gcnt_wr : gpht[id_gidx];
    assign f_ccnt = (u_valid_q && u_cho_idx_q == id_cho_idx) ? ccnt_wr : cho[id_cho_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            ghist_q     <= '0;
            u_valid_q   <= 1'b0;
            u_taken_q   <= 1'b0;
            u_lpred_q   <= 1'b0;
            u_gpred_q   <= 1'b0;
            u_lht_idx_q <= '0;
            u_cho_idx_q <= '0;
            u_gidx_q    <= '0;
            u_lh_q      <= '0;
            u_lcnt_q    <= '0;
            u_gcnt_q    <= '0;
            u_ccnt_q    <= '0;
        end else begin
            u_valid_q <= 1'b0;
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + {{(SWEEP_BITS-1){1'b0}}, 1'b1};
                    if (cnt_q == '1) state_q <= StRun;
                end
                StRun: begin
                    if (id_is_branch) begin
                        u_valid_q   <= 1'b1;
                        u_taken_q   <= id_take_or_not;
                        u_lpred_q   <= id_lpred;
                        u_gpred_q   <= id_gpred;
                        u_lht_idx_q <= id_lht_idx;
                        u_cho_idx_q <= id_cho_idx;
                        u_gidx_q    <= id_gidx;
                        u_lh_q      <= f_lh;
                        u_lcnt_q    <= f_lcnt;
                        u_gcnt_q    <= f_gcnt;
                        u_ccnt_q    <= f_ccnt;
                        ghist_q     <= {ghist_q[GHIST_BITS-2:0], id_take_or_not};
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // Tables carry no reset; the init sweep clears them.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            lht[cnt_q[LHT_BITS-1:0]]    <= '0;
            lpht[cnt_q[LHIST_BITS-1:0]] <= '0;
            gpht[cnt_q[GHIST_BITS-1:0]] <= '0;
            cho[cnt_q[CHO_BITS-1:0]]    <= '0;
        end else if (u_valid_q) begin
            lht[u_lht_idx_q] <= lht_wr;
            lpht[u_lh_q]     <= lcnt_wr;
            gpht[u_gidx_q]   <= gcnt_wr;
            cho[u_cho_idx_q] <= ccnt_wr;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{pc_i, inst_i, id_pc};

endmodule

// File: tb/tb_tournament_bpu.sv
// Bench for tournament_bpu: directed scenarios plus random update/predict rounds against
// a table-level reference model of the predictor.
module tb_tournament_bpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0, inst_i = '0, id_pc = '0;
    logic        id_is_branch = 1'b0, id_take_or_not = 1'b0, id_lpred = 1'b0, id_gpred = 1'b0;
    logic [11:0] id_gidx = '0;
    logic        pre_branch_flag_o, pre_take_or_not, pre_sel, pre_lpred, pre_gpred, bpu_ready_o;
    logic [31:0] pre_branch_target_address_o;
    logic [11:0] pre_gidx;

    tournament_bpu dut (
        .clk                         (clk),
        .rst                         (rst),
        .pc_i                        (pc_i),
        .inst_i                      (inst_i),
        .pre_branch_flag_o           (pre_branch_flag_o),
        .pre_branch_target_address_o (pre_branch_target_address_o),
        .pre_take_or_not             (pre_take_or_not),
        .pre_sel                     (pre_sel),
        .pre_lpred                   (pre_lpred),
        .pre_gpred                   (pre_gpred),
        .pre_gidx                    (pre_gidx),
        .id_is_branch                (id_is_branch),
        .id_pc                       (id_pc),
        .id_take_or_not              (id_take_or_not),
        .id_lpred                    (id_lpred),
        .id_gpred                    (id_gpred),
        .id_gidx                     (id_gidx),
        .bpu_ready_o                 (bpu_ready_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: plain integer tables updated in program order
    int m_lht [1024];
    int m_lpht[1024];
    int m_gpht[4096];
    int m_cho [4096];
    int m_ghist;

    function automatic int sat(int c, bit up);
        if (up) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        foreach (m_lht[i]) m_lht[i] = 0;
        foreach (m_lpht[i]) m_lpht[i] = 0;
        foreach (m_gpht[i]) m_gpht[i] = 0;
        foreach (m_cho[i]) m_cho[i] = 0;
        m_ghist = 0;
    endtask

    task automatic model_update(int pc, bit t, bit lp, bit gp, int gi);
        int li, lh, ci;
        li = (pc / 4) % 1024;
        ci = (pc / 4) % 4096;
        lh = m_lht[li];
        m_lpht[lh] = sat(m_lpht[lh], t);
        m_gpht[gi] = sat(m_gpht[gi], t);
        m_lht[li]  = (lh * 2 + int'(t)) % 1024;
        if (gp == t && lp != t) m_cho[ci] = sat(m_cho[ci], 1'b1);
        else if (lp == t && gp != t) m_cho[ci] = sat(m_cho[ci], 1'b0);
        m_ghist = (m_ghist * 2 + int'(t)) % 4096;
    endtask

    function automatic logic [31:0] mk_br(int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'b1100011};
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(string tag, logic [31:0] pc, logic [31:0] inst, bit is_b, int imm);
        int lh, lp, gi, gp, sel, tk;
        logic [31:0] tgt;
        @(negedge clk);
        pc_i = pc;
        inst_i = inst;
        #1;
        lh  = m_lht[int'(pc >> 2) % 1024];
        lp  = m_lpht[lh] / 2;
        gi  = (m_ghist ^ int'(pc >> 2)) % 4096;
        gp  = m_gpht[gi] / 2;
        sel = m_cho[int'(pc >> 2) % 4096] / 2;
        tk  = (sel != 0) ? gp : lp;
        tgt = (tk != 0) ? pc + 32'(imm) : pc + 32'd4;
        if (!is_b) begin
            lp = 0; gp = 0; gi = 0; sel = 0; tk = 0; tgt = 0;
        end
        cmp({tag, ".flag"}, 32'(pre_branch_flag_o), 32'(is_b));
        cmp({tag, ".take"}, 32'(pre_take_or_not), 32'(tk));
        cmp({tag, ".sel"}, 32'(pre_sel), 32'(sel));
        cmp({tag, ".lpred"}, 32'(pre_lpred), 32'(lp));
        cmp({tag, ".gpred"}, 32'(pre_gpred), 32'(gp));
        cmp({tag, ".gidx"}, 32'(pre_gidx), 32'(gi));
        cmp({tag, ".target"}, pre_branch_target_address_o, tgt);
    endtask

    task automatic upd(logic [31:0] pc, bit t, bit lp, bit gp, int gi);
        @(negedge clk);
        id_is_branch = 1'b1;
        id_pc = pc;
        id_take_or_not = t;
        id_lpred = lp;
        id_gpred = gp;
        id_gidx = 12'(gi);
        model_update(int'(pc), t, lp, gp, gi);
    endtask

    task automatic end_upd();
        @(negedge clk);
        id_is_branch = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bpu_ready_o && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic chk_zero(string tag);
        cmp({tag, ".flag"}, 32'(pre_branch_flag_o), 32'd0);
        cmp({tag, ".target"}, pre_branch_target_address_o, 32'd0);
        cmp({tag, ".misc"}, {27'd0, pre_take_or_not, pre_sel, pre_lpred, pre_gpred, bpu_ready_o},
            32'd0);
        cmp({tag, ".gidx"}, 32'(pre_gidx), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] pc, inst;
        int imm;
        bit is_b;
        model_reset();

        // Reset: outputs quiet even with a branch presented
        pc_i = 32'h100;
        inst_i = mk_br(16);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");

        // Init sweep: branches not flagged, updates dropped
        @(negedge clk);
        rst = 1'b1;
        id_is_branch = 1'b1;
        id_pc = 32'h100;
        id_take_or_not = 1'b1;
        id_gidx = 12'h040;
        repeat (3) @(posedge clk);
        #1;
        cmp("init_flag", 32'(pre_branch_flag_o), 32'd0);
        cmp("init_ready", 32'(bpu_ready_o), 32'd0);
        id_is_branch = 1'b0;
        wait_ready(n);
        cmp("init_len", 32'(n + 3), 32'd4096);

        // Fresh predictor: not-taken, local chosen, fall-through target
        chk_pred("fresh", 32'h100, mk_br(16), 1'b1, 16);
        cmp("fresh_tgt", pre_branch_target_address_o, 32'h104);

        // Repeated taken updates saturate counters
        repeat (3) upd(32'h100, 1'b1, 1'b0, 1'b0, 12'h040);
        end_upd();
        chk_pred("sat3", 32'h100, mk_br(16), 1'b1, 16);
        cmp("ghist111", 32'(pre_gidx[2:0]), 32'd7);
        upd(32'h100, 1'b1, 1'b0, 1'b0, 12'h040);
        end_upd();
        chk_pred("sat4", 32'h100, mk_br(16), 1'b1, 16);

        // Back-to-back GPHT updates must forward: 1 -> 3, then not-taken leaves 2
        upd(32'h200, 1'b1, 1'b0, 1'b0, 12'h800);
        end_upd();
        upd(32'h200, 1'b1, 1'b0, 1'b0, 12'h800);
        upd(32'h200, 1'b1, 1'b0, 1'b0, 12'h800);
        upd(32'h200, 1'b0, 1'b0, 1'b0, 12'h800);
        end_upd();
        pc = 32'(((12'h800 ^ 12'(m_ghist)) & 12'hfff)) << 2;
        chk_pred("gfwd", pc, mk_br(8), 1'b1, 8);
        cmp("gfwd_gpred", 32'(pre_gpred), 32'd1);

        // Chooser training; mid-write predict sees the old entry
        upd(32'h800, 1'b1, 1'b0, 1'b1, 12'h300);
        upd(32'h800, 1'b1, 1'b0, 1'b1, 12'h301);
        @(negedge clk);
        id_is_branch = 1'b0;
        pc_i = 32'h800;
        inst_i = mk_br(32);
        #1;
        cmp("cho_old", 32'(pre_sel), 32'd0);
        chk_pred("cho2", 32'h800, mk_br(32), 1'b1, 32);
        cmp("cho_sel", 32'(pre_sel), 32'd1);

        // Train pc=4 local history to all-taken, then negative offset wraps
        repeat (13) upd(32'h4, 1'b1, 1'b1, 1'b1, 12'h123);
        end_upd();
        chk_pred("neg", 32'h4, mk_br(-8), 1'b1, -8);
        cmp("neg_take", 32'(pre_take_or_not), 32'd1);
        cmp("neg_tgt", pre_branch_target_address_o, 32'hFFFF_FFFC);

        // Reset between U1 and U2: outputs zero, sweep restarts, tables cleared
        upd(32'h4, 1'b1, 1'b1, 1'b1, 12'h123);
        @(posedge clk);
        #1;
        rst = 1'b0;
        id_is_branch = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_ready(n);
        cmp("reinit_len", 32'(n), 32'd4096);
        chk_pred("cleared", 32'h4, mk_br(-8), 1'b1, -8);

        // Random rounds
        repeat (150) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                pc = 32'($urandom_range(0, 31)) << 2;
                if ($urandom_range(0, 3) == 0) pc = 32'h100;
                upd(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15));
            end
            end_upd();
            repeat (2) begin
                pc = ($urandom_range(0, 7) == 0) ? $urandom() & 32'hFFFF_FFFC
                                                 : 32'($urandom_range(0, 31)) << 2;
                imm = (int'($urandom_range(0, 8191)) - 4096) & ~1;
                is_b = ($urandom_range(0, 4) != 0);
                inst = mk_br(imm);
                if (!is_b) inst[6:0] = 7'b0010011;
                chk_pred("rnd", pc, inst, is_b, imm);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
